// File: rtl/tensor_core_pkg.sv
// rtl/tensor_core_pkg.sv - shared element, matrix, opcode and state types for the tensor core staging block
package tensor_core_pkg;

  localparam int BUS_WIDTH = 7;

  typedef logic signed [BUS_WIDTH:0] elem_t;
  typedef elem_t [0:2][0:2] mat3_t;

  typedef enum logic [1:0] {
    OP_MATMUL = 2'b00,
    OP_ADD    = 2'b01,
    OP_RELU   = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/tensor_core_register_file.sv
// rtl/tensor_core_register_file.sv - operand/result staging and launch sequencing for small_tensor_core
// Optional RESULT_FORWARD_EN: captured result is also copied into matrix A for op chaining.
module tensor_core_register_file
  import tensor_core_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic                 tensor_core_clock,
  input  logic                 tensor_core_reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [4:0]           wr_addr,
  input  logic [BUS_WIDTH:0]   wr_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           rd_addr,
  output logic [BUS_WIDTH:0]   rd_data,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 addr_err,
  output mat3_t                tensor_core_input1,
  output mat3_t                tensor_core_input2,
  output logic                 tensor_core_register_file_write_enable,
  output logic                 should_start_tensor_core,
  output logic [1:0]           operation_select,
  input  mat3_t                tensor_core_output
);

  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  mat3_t              a_q, b_q, res_q;
  mat3_t              a_d, b_d;
  logic               rv_q, err_q, we_q, start_q;
  logic [1:0]         op_q;
  logic               wr_hit;
  logic               wr_fire, cmd_fire;

  assign wr_ready  = (state_q == ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && !wr_valid;
  assign wr_fire   = wr_valid && wr_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Addresses 0-8 map to A, 9-17 to B, both row-major; anything else is a miss.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    wr_hit = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (wr_addr == 5'(r * 3 + c)) begin
          a_d[r][c] = wr_data;
          wr_hit    = 1'b1;
        end
        if (wr_addr == 5'(9 + r * 3 + c)) begin
          b_d[r][c] = wr_data;
          wr_hit    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (rd_addr == 4'(r * 3 + c)) rd_data = res_q[r][c];
      end
    end
  end

  always_ff @(posedge tensor_core_clock) begin
    if (!tensor_core_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      op_q    <= 2'b00;
    end else begin
      we_q    <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_fire) begin
            if (wr_hit) begin
              a_q  <= a_d;
              b_q  <= b_d;
              we_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (cmd_fire) begin
            op_q    <= cmd_op;
            rv_q    <= 1'b0;
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          cnt_q   <= CNT_W'(COMPUTE_CYCLES - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_CAPTURE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_CAPTURE: begin
          res_q   <= tensor_core_output;
          rv_q    <= 1'b1;
`ifdef RESULT_FORWARD_EN
          a_q     <= tensor_core_output;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy                                   = (state_q != ST_IDLE);
  assign result_valid                           = rv_q;
  assign addr_err                               = err_q;
  assign tensor_core_input1                     = a_q;
  assign tensor_core_input2                     = b_q;
  assign tensor_core_register_file_write_enable = we_q;
  assign should_start_tensor_core               = start_q;
  assign operation_select                       = op_q;

endmodule
